// File: rtl/dtw_result_streamer.sv
// dtw_result_streamer
// Drains the DTW sink FIFO and emits every {qid, position, minval} result as a
// 3-beat 32-bit AXI4-Stream packet (qid, position, zero-extended minval; tlast
// on the third beat). Counts fully sent packets.
// Optional build macro DTW_RESULT_THRESH_EN adds a minval threshold filter:
// results with minval > thresh are dropped and counted in drop_count.
module dtw_result_streamer #(
    parameter int dtw_dwidth = 16,
    parameter int axi_dwidth = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  busy,
    input  logic                  fifo_empty,
    output logic                  fifo_rden,
    input  logic [dtw_dwidth-1:0] fifo_minval,
    input  logic [31:0]           fifo_position,
    input  logic [31:0]           fifo_qid,
    output logic [axi_dwidth-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [31:0]           pkt_count
`ifdef DTW_RESULT_THRESH_EN
    ,
    input  logic [dtw_dwidth-1:0] thresh,
    output logic [31:0]           drop_count
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        BEAT0,
        BEAT1,
        BEAT2
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           qid_q, qid_d;
    logic [31:0]           pos_q, pos_d;
    logic [31:0]           minval_q, minval_d;
    logic [31:0]           pkt_q, pkt_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [axi_dwidth-1:0] tdata_q, tdata_d;
    logic                  busy_q, busy_d;
    logic                  hs;
`ifdef DTW_RESULT_THRESH_EN
    logic [31:0]           drop_q, drop_d;
`endif

    // A read is only ever issued from IDLE, never while empty or in reset.
    assign fifo_rden = !rst && (state_q == IDLE) && en && !fifo_empty;
    assign hs        = tvalid_q && m_axis_tready;

    // Next-state, holding-register and counter logic.
    // Stream outputs are decoded from the next state so they come straight
    // from flops; the stall case keeps state, so they hold automatically.
    always_comb begin
        state_d  = state_q;
        qid_d    = qid_q;
        pos_d    = pos_q;
        minval_d = minval_q;
        pkt_d    = pkt_q;
`ifdef DTW_RESULT_THRESH_EN
        drop_d   = drop_q;
`endif
        case (state_q)
            IDLE: begin
                if (fifo_rden) state_d = CAPTURE;
            end
            CAPTURE: begin
                qid_d    = fifo_qid;
                pos_d    = fifo_position;
                minval_d = 32'(fifo_minval);
                state_d  = BEAT0;
`ifdef DTW_RESULT_THRESH_EN
                if (fifo_minval > thresh) begin
                    drop_d  = drop_q + 32'd1;
                    state_d = IDLE;
                end
`endif
            end
            BEAT0: begin
                if (hs) state_d = BEAT1;
            end
            BEAT1: begin
                if (hs) state_d = BEAT2;
            end
            BEAT2: begin
                if (hs) begin
                    pkt_d   = pkt_q + 32'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        tvalid_d = (state_d == BEAT0) || (state_d == BEAT1) || (state_d == BEAT2);
        tlast_d  = (state_d == BEAT2);
        busy_d   = (state_d != IDLE);
        case (state_d)
            BEAT0:   tdata_d = axi_dwidth'(qid_d);
            BEAT1:   tdata_d = axi_dwidth'(pos_d);
            BEAT2:   tdata_d = axi_dwidth'(minval_d);
            default: tdata_d = '0;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            qid_q    <= '0;
            pos_q    <= '0;
            minval_q <= '0;
            pkt_q    <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            busy_q   <= 1'b0;
`ifdef DTW_RESULT_THRESH_EN
            drop_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            qid_q    <= qid_d;
            pos_q    <= pos_d;
            minval_q <= minval_d;
            pkt_q    <= pkt_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            busy_q   <= busy_d;
`ifdef DTW_RESULT_THRESH_EN
            drop_q   <= drop_d;
`endif
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tdata  = tdata_q;
    assign busy          = busy_q;
    assign pkt_count     = pkt_q;
`ifdef DTW_RESULT_THRESH_EN
    assign drop_count    = drop_q;
`endif

endmodule

// File: tb/tb_dtw_result_streamer.sv
// Scoreboard bench for dtw_result_streamer: a FIFO model feeds entries,
// expected beats are queued when entries are pushed, and a monitor pops and
// compares on every stream handshake.
module tb_dtw_result_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        busy;
    logic        fifo_empty;
    logic        fifo_rden;
    logic [15:0] fifo_minval = '0;
    logic [31:0] fifo_position = '0;
    logic [31:0] fifo_qid = '0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [31:0] pkt_count;
`ifdef DTW_RESULT_THRESH_EN
    logic [15:0] thresh = 16'hFFFF;
    logic [31:0] drop_count;
`endif

    int tests = 0;
    int fails = 0;

    // FIFO model storage
    logic [31:0] mem_qid [0:63];
    logic [31:0] mem_pos [0:63];
    logic [15:0] mem_min [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;

    logic [32:0] sb [$];
    int rden_count = 0;
    int rden_bad = 0;
    int cyc = 0;
    int rden_cyc [$];

    always #5 clk = ~clk;

    dtw_result_streamer #(
        .dtw_dwidth(16),
        .axi_dwidth(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .busy(busy),
        .fifo_empty(fifo_empty),
        .fifo_rden(fifo_rden),
        .fifo_minval(fifo_minval),
        .fifo_position(fifo_position),
        .fifo_qid(fifo_qid),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .pkt_count(pkt_count)
`ifdef DTW_RESULT_THRESH_EN
        ,
        .thresh(thresh),
        .drop_count(drop_count)
`endif
    );

    assign fifo_empty = (wr_ptr == rd_ptr);

    // FIFO read side: data appears the cycle after rden
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rden) begin
            fifo_qid      <= mem_qid[rd_ptr];
            fifo_position <= mem_pos[rd_ptr];
            fifo_minval   <= mem_min[rd_ptr];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    // Monitor: beat scoreboard and rden bookkeeping
    always @(negedge clk) begin
        if (fifo_rden) begin
            rden_count++;
            rden_cyc.push_back(cyc);
            if (fifo_empty) rden_bad++;
        end
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL beat_unexpected: got data=%h last=%0b, none expected", m_axis_tdata, m_axis_tlast);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                if ({m_axis_tlast, m_axis_tdata} !== e) begin
                    fails++;
                    $display("FAIL beat: got last=%0b data=%h, expected last=%0b data=%h",
                             m_axis_tlast, m_axis_tdata, e[32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    // Called at posedge+1: load a FIFO entry and queue the beats it should produce
    task automatic push_entry(input logic [31:0] q, input logic [31:0] p, input logic [15:0] m, input int nbeats);
        mem_qid[wr_ptr] = q;
        mem_pos[wr_ptr] = p;
        mem_min[wr_ptr] = m;
        wr_ptr = wr_ptr + 1;
        if (nbeats > 0) sb.push_back({1'b0, q});
        if (nbeats > 1) sb.push_back({1'b0, p});
        if (nbeats > 2) sb.push_back({1'b1, 16'h0000, m});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (!(fifo_empty && !busy && sb.size() == 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: still busy=%0b pending=%0d after %0d cycles, expected idle",
                     name, busy, sb.size(), budget);
        end
        step();
    endtask

    task automatic wait_for(input string name, input bit want_last, input int budget);
        int n;
        n = 0;
        while (!(m_axis_tvalid && (!want_last || m_axis_tlast)) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: tvalid=%0b after %0d cycles, expected 1", name, m_axis_tvalid, budget);
        end
    endtask

    initial begin
        int base;
        repeat (3) step();
        // reset state (rst still high)
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_tdata", m_axis_tdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pkt_count", pkt_count, 32'd0);
        check("rst_rden", 32'(fifo_rden), 32'd0);
        rst = 1'b0;
        en  = 1'b1;
        step();

        // 1: single entry, tready=1
        base = rden_count;
        push_entry(32'h12, 32'h1F4, 16'h00AB, 3);
        wait_drain("t1", 40);
        check("t1_pkt_count", pkt_count, 32'd1);
        check("t1_rden_pulses", 32'(rden_count - base), 32'd1);

        // 2: stall four cycles in BEAT1
        m_axis_tready = 1'b0;
        push_entry(32'h12, 32'h1F4, 16'h00AB, 3);
        wait_for("t2_beat0", 1'b0, 20);
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        base = rden_count;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_stall_tvalid", 32'(m_axis_tvalid), 32'd1);
            check("t2_stall_tdata", m_axis_tdata, 32'h1F4);
            check("t2_stall_tlast", 32'(m_axis_tlast), 32'd0);
        end
        step();
        check("t2_no_rden", 32'(rden_count - base), 32'd0);
        m_axis_tready = 1'b1;
        wait_drain("t2", 40);
        check("t2_pkt_count", pkt_count, 32'd2);

        // 3: three queued entries back to back
        rden_cyc.delete();
        base = rden_count;
        push_entry(32'hA1, 32'h100, 16'h0001, 3);
        push_entry(32'hA2, 32'h200, 16'hFFFF, 3);
        push_entry(32'hA3, 32'h300, 16'h8000, 3);
        wait_drain("t3", 60);
        check("t3_rden_pulses", 32'(rden_count - base), 32'd3);
        if (rden_cyc.size() == 3) begin
            check("t3_rden_gap01", 32'(rden_cyc[1] - rden_cyc[0]), 32'd5);
            check("t3_rden_gap12", 32'(rden_cyc[2] - rden_cyc[1]), 32'd5);
        end
        check("t3_pkt_count", pkt_count, 32'd5);

        // 4: en dropped during BEAT0
        base = rden_count;
        push_entry(32'hB1, 32'h111, 16'h0022, 3);
        push_entry(32'hB2, 32'h222, 16'h0033, 3);
        wait_for("t4_beat0", 1'b0, 20);
        en = 1'b0;
        repeat (12) step();
        check("t4_pkt_count_hold", pkt_count, 32'd6);
        check("t4_rden_hold", 32'(rden_count - base), 32'd1);
        check("t4_fifo_nonempty", 32'(fifo_empty), 32'd0);
        check("t4_busy_hold", 32'(busy), 32'd0);
        en = 1'b1;
        wait_drain("t4", 40);
        check("t4_pkt_count", pkt_count, 32'd7);

        // 5: reset during BEAT2, next entry goes out as a fresh packet
        push_entry(32'hC1, 32'h333, 16'h0044, 2);
        push_entry(32'hC2, 32'h444, 16'h0055, 3);
        wait_for("t5_beat2", 1'b1, 20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("t5_tlast", 32'(m_axis_tlast), 32'd0);
        check("t5_pkt_count", pkt_count, 32'd0);
        wait_drain("t5", 40);
        check("t5_pkt_count_after", pkt_count, 32'd1);

`ifdef DTW_RESULT_THRESH_EN
        // 6: threshold filter
        check("t6_drop_start", drop_count, 32'd0);
        thresh = 16'h0100;
        push_entry(32'hD1, 32'h555, 16'h00FF, 3);
        push_entry(32'hD2, 32'h666, 16'h0100, 3);
        push_entry(32'hD3, 32'h777, 16'h0101, 0);
        wait_drain("t6", 60);
        check("t6_pkt_count", pkt_count, 32'd3);
        check("t6_drop_count", drop_count, 32'd1);
`endif

        check("rden_while_empty", 32'(rden_bad), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
